// File: rtl/vga_sprite_compositor.sv
// rtl/vga_sprite_compositor.sv - VGA timing generator with N-channel sprite compositor and collision flags
module vga_sprite_compositor #(
  parameter int          H_ACT        = 640,
  parameter int          H_FRONT      = 16,
  parameter int          H_SYNC       = 96,
  parameter int          H_BACK       = 48,
  parameter int          V_ACT        = 480,
  parameter int          V_FRONT      = 10,
  parameter int          V_SYNC       = 2,
  parameter int          V_BACK       = 33,
  parameter int          N_SPR        = 4,
  parameter int          SPR_MAX      = 64,
  parameter int          GROUND_Y     = 400,
  parameter logic [23:0] GROUND_COLOR = 24'h33FF33,
  parameter logic [23:0] BG_COLOR     = 24'h000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_SPR-1:0]    spr_en,
  input  logic [N_SPR*10-1:0] spr_x,
  input  logic [N_SPR*10-1:0] spr_y,
  input  logic [N_SPR*7-1:0]  spr_w,
  input  logic [N_SPR*7-1:0]  spr_h,
  input  logic [N_SPR*24-1:0] spr_color,
  output logic [N_SPR*6-1:0]  spr_lx,
  output logic [N_SPR*6-1:0]  spr_ly,
  input  logic [N_SPR-1:0]    spr_bit,
  output logic                vga_hs,
  output logic                vga_vs,
  output logic                vga_blank_n,
  output logic [7:0]          vga_r,
  output logic [7:0]          vga_g,
  output logic [7:0]          vga_b,
  output logic                vga_clk,
  output logic                frame_start,
  output logic [N_SPR-1:0]    coll_flags
);

  localparam logic [10:0] H_LAST  = 11'(H_ACT + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [10:0] V_LAST  = 11'(V_ACT + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [10:0] H_ACT_L = 11'(H_ACT);
  localparam logic [10:0] V_ACT_L = 11'(V_ACT);
  localparam logic [10:0] HS_BEG  = 11'(H_ACT + H_FRONT);
  localparam logic [10:0] HS_END  = 11'(H_ACT + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_BEG  = 11'(V_ACT + V_FRONT);
  localparam logic [10:0] VS_END  = 11'(V_ACT + V_FRONT + V_SYNC);
  localparam logic [10:0] GND_Y   = 11'(GROUND_Y);
  localparam logic [10:0] LMASK   = 11'(SPR_MAX - 1);

  logic        pix_en;
  logic [10:0] h_cnt, v_cnt;
  logic        frame_edge;
  logic        raw_hs, raw_vs, raw_act, raw_gnd;

  logic [N_SPR-1:0] sh_en;
  logic [9:0]       sh_x     [N_SPR];
  logic [9:0]       sh_y     [N_SPR];
  logic [6:0]       sh_w     [N_SPR];
  logic [6:0]       sh_h     [N_SPR];
  logic [23:0]      sh_color [N_SPR];

  logic [N_SPR-1:0] hit, hit_q, opq, coll_acc;
  logic [10:0]      dx [N_SPR];
  logic [10:0]      dy [N_SPR];
  logic             s1_hs, s1_vs, s1_act, s1_gnd;
  logic             s2_hs, s2_vs, s2_act;
  logic [23:0]      s2_col, col;
  logic [3:0]       n_opq;

  assign vga_clk    = ~pix_en;
  assign frame_edge = pix_en && (h_cnt == 11'd0) && (v_cnt == V_ACT_L);
  assign raw_hs     = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
  assign raw_vs     = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
  assign raw_act    = (h_cnt < H_ACT_L) && (v_cnt < V_ACT_L);
  assign raw_gnd    = (v_cnt == GND_Y);

  // 11-bit bounds: a sprite running past the screen edge is clipped rather than wrapped
  always_comb begin
    for (int i = 0; i < N_SPR; i++) begin
      hit[i] = sh_en[i]
            && ({1'b0, sh_x[i]} <= h_cnt) && (h_cnt < {1'b0, sh_x[i]} + {4'b0000, sh_w[i]})
            && ({1'b0, sh_y[i]} <= v_cnt) && (v_cnt < {1'b0, sh_y[i]} + {4'b0000, sh_h[i]});
      dx[i]  = (h_cnt - {1'b0, sh_x[i]}) & LMASK;
      dy[i]  = (v_cnt - {1'b0, sh_y[i]}) & LMASK;
    end
  end

  // Descending scan so the lowest-index opaque sprite wins
  always_comb begin
    opq   = hit_q & spr_bit;
    n_opq = 4'd0;
    col   = s1_gnd ? GROUND_COLOR : BG_COLOR;
    for (int i = N_SPR - 1; i >= 0; i--) begin
      n_opq = n_opq + {3'b000, opq[i]};
      if (opq[i]) col = sh_color[i];
    end
    if (!s1_act) col = 24'h000000;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_en      <= 1'b0;
      h_cnt       <= 11'd0;
      v_cnt       <= 11'd0;
      sh_en       <= '0;
      for (int i = 0; i < N_SPR; i++) begin
        sh_x[i]     <= 10'd0;
        sh_y[i]     <= 10'd0;
        sh_w[i]     <= 7'd0;
        sh_h[i]     <= 7'd0;
        sh_color[i] <= 24'h000000;
      end
      hit_q       <= '0;
      spr_lx      <= '0;
      spr_ly      <= '0;
      s1_hs       <= 1'b1;
      s1_vs       <= 1'b1;
      s1_act      <= 1'b0;
      s1_gnd      <= 1'b0;
      s2_hs       <= 1'b1;
      s2_vs       <= 1'b1;
      s2_act      <= 1'b0;
      s2_col      <= 24'h000000;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= 8'd0;
      vga_g       <= 8'd0;
      vga_b       <= 8'd0;
      frame_start <= 1'b0;
      coll_acc    <= '0;
      coll_flags  <= '0;
    end else begin
      pix_en      <= ~pix_en;
      frame_start <= frame_edge;
      if (frame_edge) begin
        sh_en <= spr_en;
        for (int i = 0; i < N_SPR; i++) begin
          sh_x[i]     <= spr_x[i*10 +: 10];
          sh_y[i]     <= spr_y[i*10 +: 10];
          sh_w[i]     <= spr_w[i*7 +: 7];
          sh_h[i]     <= spr_h[i*7 +: 7];
          sh_color[i] <= spr_color[i*24 +: 24];
        end
        coll_flags <= coll_acc;
        coll_acc   <= '0;
      end else if (pix_en && (n_opq >= 4'd2)) begin
        coll_acc <= coll_acc | opq;
      end
      if (pix_en) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= 11'd0;
          v_cnt <= (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
        end else begin
          h_cnt <= h_cnt + 11'd1;
        end
        hit_q  <= hit;
        for (int i = 0; i < N_SPR; i++) begin
          if (hit[i]) begin
            spr_lx[i*6 +: 6] <= dx[i][5:0];
            spr_ly[i*6 +: 6] <= dy[i][5:0];
          end
        end
        s1_hs       <= raw_hs;
        s1_vs       <= raw_vs;
        s1_act      <= raw_act;
        s1_gnd      <= raw_gnd;
        s2_hs       <= s1_hs;
        s2_vs       <= s1_vs;
        s2_act      <= s1_act;
        s2_col      <= col;
        vga_hs      <= s2_hs;
        vga_vs      <= s2_vs;
        vga_blank_n <= s2_act;
        vga_r       <= s2_col[23:16];
        vga_g       <= s2_col[15:8];
        vga_b       <= s2_col[7:0];
      end
    end
  end

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// tb/tb_vga_sprite_compositor.sv - directed bench for vga_sprite_compositor on a reduced 56x37 raster
module tb_vga_sprite_compositor;

  localparam int HT = 56;
  localparam int VT = 37;
  localparam int FR = HT * VT;
  localparam int FS_N = 2 + 2 * (30 * HT);

  logic         clk;
  logic         rst;
  logic [3:0]   spr_en;
  logic [39:0]  spr_x, spr_y;
  logic [27:0]  spr_w, spr_h;
  logic [95:0]  spr_color;
  logic [23:0]  spr_lx, spr_ly;
  logic [3:0]   spr_bit;
  logic         vga_hs, vga_vs, vga_blank_n, vga_clk, frame_start;
  logic [7:0]   vga_r, vga_g, vga_b;
  logic [3:0]   coll_flags;
  logic [3:0]   mode;

  int checks = 0;
  int errors = 0;
  int fs_cnt = 0;
  int n;
  int mp, mf, mv, mh;

  logic [23:0] img  [2][VT][HT];
  logic        hs_a [2][VT][HT];
  logic        vs_a [2][VT][HT];
  logic        bl_a [2][VT][HT];

  vga_sprite_compositor #(
    .H_ACT(40), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
    .V_ACT(30), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .N_SPR(4), .SPR_MAX(64), .GROUND_Y(20),
    .GROUND_COLOR(24'h33FF33), .BG_COLOR(24'h000000)
  ) dut (
    .clk(clk), .rst(rst),
    .spr_en(spr_en), .spr_x(spr_x), .spr_y(spr_y), .spr_w(spr_w), .spr_h(spr_h),
    .spr_color(spr_color), .spr_lx(spr_lx), .spr_ly(spr_ly), .spr_bit(spr_bit),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_clk(vga_clk), .frame_start(frame_start), .coll_flags(coll_flags)
  );

  always #10 clk = ~clk;

  // External bitmap store: mode bit set means only the diagonal lx==ly is opaque
  always_comb begin
    for (int i = 0; i < 4; i++)
      spr_bit[i] = mode[i] ? (spr_lx[i*6 +: 6] == spr_ly[i*6 +: 6]) : 1'b1;
  end

  always @(posedge clk or negedge rst)
    if (!rst) n <= 0;
    else      n <= n + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic set_spr(input int i, input logic en, input int x, input int y,
                         input int w, input int hgt, input logic [23:0] c);
    spr_en[i]             = en;
    spr_x[i*10 +: 10]     = 10'(x);
    spr_y[i*10 +: 10]     = 10'(y);
    spr_w[i*7 +: 7]       = 7'(w);
    spr_h[i*7 +: 7]       = 7'(hgt);
    spr_color[i*24 +: 24] = c;
  endtask

  task automatic wait_n(input int t);
    while (n < t) @(negedge clk);
  endtask

  task automatic pix(input string tag, input int f, input int x, input int y, input logic [23:0] exp);
    check(tag, {8'h00, img[f % 2][y][x]}, {8'h00, exp});
  endtask

  // Output pixel p (counter position p) is on the pins after 3 pixel periods
  always @(negedge clk) begin
    if (rst && n >= 6 && !n[0]) begin
      mp = (n - 6) / 2;
      mf = (mp / FR) % 2;
      mv = (mp % FR) / HT;
      mh = mp % HT;
      img[mf][mv][mh]  = {vga_r, vga_g, vga_b};
      hs_a[mf][mv][mh] = vga_hs;
      vs_a[mf][mv][mh] = vga_vs;
      bl_a[mf][mv][mh] = vga_blank_n;
    end
    if (rst && frame_start) begin
      check("fs_pos", n % (2 * FR), FS_N);
      fs_cnt++;
    end
  end

  initial begin
    int hs_low, vs_low, bl_hi;
    clk = 1'b0;
    rst = 1'b0;
    spr_en = '0; spr_x = '0; spr_y = '0; spr_w = '0; spr_h = '0; spr_color = '0;
    mode = 4'b0001;
    set_spr(0, 1'b1, 10, 14, 8, 8, 24'h0000FF);
    repeat (3) @(negedge clk);
    check("rst_hs", vga_hs, 1);
    check("rst_vs", vga_vs, 1);
    check("rst_blank", vga_blank_n, 0);
    check("rst_rgb", {vga_r, vga_g, vga_b}, 0);
    check("rst_fs", frame_start, 0);
    check("rst_coll", coll_flags, 0);
    check("rst_lxly", {spr_lx, spr_ly}, 0);
    rst = 1'b1;
    @(negedge clk);
    check("vga_clk_n1", vga_clk, 0);
    @(negedge clk);
    check("vga_clk_n2", vga_clk, 1);

    // Frame 0: raster timing, no sprite before the first frame boundary
    wait_n(6 + 2 * FR);
    hs_low = 0; vs_low = 0; bl_hi = 0;
    for (int v = 0; v < VT; v++)
      for (int h = 0; h < HT; h++) begin
        hs_low += hs_a[0][v][h] ? 0 : 1;
        vs_low += vs_a[0][v][h] ? 0 : 1;
        bl_hi  += bl_a[0][v][h] ? 1 : 0;
      end
    check("hs_low_total", hs_low, 6 * VT);
    check("vs_low_total", vs_low, 2 * HT);
    check("blank_total", bl_hi, 40 * 30);
    check("hs_43", hs_a[0][0][43], 1);
    check("hs_44", hs_a[0][0][44], 0);
    check("hs_49", hs_a[0][0][49], 0);
    check("hs_50", hs_a[0][0][50], 1);
    check("vs_31", vs_a[0][31][55], 1);
    check("vs_32", vs_a[0][32][0], 0);
    check("vs_34", vs_a[0][34][0], 1);
    check("bl_39_29", bl_a[0][29][39], 1);
    check("bl_40_0", bl_a[0][0][40], 0);
    check("bl_0_30", bl_a[0][30][0], 0);
    pix("f0_nospr", 0, 10, 14, 24'h000000);
    pix("f0_ground", 0, 16, 20, 24'h33FF33);

    // Mid-frame-1 input change must not show until frame 2
    wait_n(2 * (FR + 10 * HT));
    set_spr(0, 1'b1, 30, 3, 4, 4, 24'hFF0000);
    set_spr(1, 1'b1, 33, 6, 4, 4, 24'h00FF00);
    set_spr(2, 1'b1, 36, 25, 32, 2, 24'hFFFFFF);
    set_spr(3, 1'b1, 0, 0, 0, 4, 24'hFFFFFF);
    wait_n(FS_N + 2 * FR + 10);
    check("coll_f1", coll_flags, 4'b0000);
    wait_n(6 + 4 * FR);
    pix("f1_diag_16_20", 1, 16, 20, 24'h0000FF);
    pix("f1_ground_17_20", 1, 17, 20, 24'h33FF33);
    pix("f1_latch_17_21", 1, 17, 21, 24'h0000FF);
    pix("f1_diag_10_14", 1, 10, 14, 24'h0000FF);
    pix("f1_diag_13_17", 1, 13, 17, 24'h0000FF);
    pix("f1_bg_14_17", 1, 14, 17, 24'h000000);
    pix("f1_notyet_33_6", 1, 33, 6, 24'h000000);
    pix("f1_ground_0", 1, 0, 20, 24'h33FF33);
    pix("f1_ground_39", 1, 39, 20, 24'h33FF33);
    pix("f1_blank_45", 1, 45, 20, 24'h000000);

    // Frame 2 draws the 1-pixel overlap; remove it for frame 3
    wait_n(2 * (2 * FR + 10 * HT));
    set_spr(1, 1'b1, 34, 7, 4, 4, 24'h00FF00);
    wait_n(FS_N + 4 * FR + 10);
    check("coll_f2", coll_flags, 4'b0011);
    wait_n(6 + 6 * FR);
    pix("f2_prio_33_6", 2, 33, 6, 24'hFF0000);
    pix("f2_s0_32_5", 2, 32, 5, 24'hFF0000);
    pix("f2_transp_31_3", 2, 31, 3, 24'h000000);
    pix("f2_s1_34_6", 2, 34, 6, 24'h00FF00);
    pix("f2_s1_33_7", 2, 33, 7, 24'h00FF00);
    pix("f2_bg_37_6", 2, 37, 6, 24'h000000);
    pix("f2_clip_36_25", 2, 36, 25, 24'hFFFFFF);
    pix("f2_clip_39_26", 2, 39, 26, 24'hFFFFFF);
    pix("f2_nowrap_0_25", 2, 0, 25, 24'h000000);
    pix("f2_nowrap_5_26", 2, 5, 26, 24'h000000);
    pix("f2_nowrap_27_26", 2, 27, 26, 24'h000000);
    pix("f2_nowrap_0_27", 2, 0, 27, 24'h000000);
    pix("f2_w0_0_0", 2, 0, 0, 24'h000000);
    pix("f2_w0_2_2", 2, 2, 2, 24'h000000);

    // Restore the overlap for frame 4
    wait_n(2 * (3 * FR + 10 * HT));
    set_spr(1, 1'b1, 33, 6, 4, 4, 24'h00FF00);
    wait_n(FS_N + 6 * FR + 10);
    check("coll_f3", coll_flags, 4'b0000);
    wait_n(6 + 8 * FR);
    pix("f3_s0_33_6", 3, 33, 6, 24'hFF0000);
    pix("f3_s1_34_7", 3, 34, 7, 24'h00FF00);
    pix("f3_bg_34_6", 3, 34, 6, 24'h000000);
    wait_n(FS_N + 8 * FR + 10);
    check("coll_f4", coll_flags, 4'b0011);

    // Asynchronous reset mid-line at h=20, v=10 of frame 5
    wait_n(2 * (5 * FR + 10 * HT + 20));
    check("pre_rst_blank", vga_blank_n, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_hs", vga_hs, 1);
    check("mid_rst_vs", vga_vs, 1);
    check("mid_rst_blank", vga_blank_n, 0);
    check("mid_rst_rgb", {vga_r, vga_g, vga_b}, 0);
    check("mid_rst_coll", coll_flags, 0);
    check("mid_rst_fs", frame_start, 0);
    check("mid_rst_lxly", {spr_lx, spr_ly}, 0);
    check("mid_rst_vga_clk", vga_clk, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_n(6 + 2 * FR);
    pix("r0_nospr_31_4", 0, 31, 4, 24'h000000);
    pix("r0_nospr_33_6", 0, 33, 6, 24'h000000);
    pix("r0_ground_0_20", 0, 0, 20, 24'h33FF33);
    check("r0_hs_44", hs_a[0][0][44], 0);
    check("fs_count", fs_cnt, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
